// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
package uart_pkg;

  // Receive sequencer state encoding
  localparam int unsigned STATE_W    = 3;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_START   = 3'd1;
  localparam logic [2:0]  ST_DATA    = 3'd2;
  localparam logic [2:0]  ST_STOP    = 3'd3;
  localparam logic [2:0]  ST_RECOVER = 3'd4;

  // Line level when nothing is being sent
  localparam logic        IDLE_LVL   = 1'b1;

  // Number of flops in the input synchroniser
  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the raw serial line; resets to the idle line level.
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Shift the asynchronous line through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_DEPTH{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: finds the start bit, strobes the sipo once per data bit
// at mid-bit, checks the stop bit and reports frame completion or framing error.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rxin,
  output logic                         rx_bit,
  output logic                         shift,
  output logic                         sipo_clr,
  output logic                         rx_done,
  output logic                         frame_err,
  output logic                         busy,
  output logic [$clog2(DATA_BITS)-1:0] bit_idx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // Start-bit centre, counting the edge that enters START as the first count
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               shift_q, shift_d;
  logic               clr_q, clr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxin),
    .q_o (rx_bit)
  );

  // State, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_bit) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_bit) begin
            state_d = ST_DATA;
            idx_d   = '0;
            clr_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_bit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        // Wait out a break so a held-low line does not retrigger starts
        if (rx_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign shift     = shift_q;
  assign sipo_clr  = clr_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign bit_idx   = idx_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural sipo attached.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DB    = 5;
  localparam int          FRAME = (DB + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxin;
  logic          rx_bit, shift, sipo_clr, rx_done, frame_err, busy;
  logic [2:0]    bit_idx;
  logic [DB-1:0] dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxin      (rxin),
    .rx_bit    (rx_bit),
    .shift     (shift),
    .sipo_clr  (sipo_clr),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy),
    .bit_idx   (bit_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LSB-first sipo
  always @(posedge clk or posedge rst) begin
    if (rst)           dout <= '0;
    else if (sipo_clr) dout <= '0;
    else if (shift)    dout <= {rx_bit, dout[DB-1:1]};
  end

  // Event log, sampled on the falling edge
  int            shift_t[$];
  int            shift_i[$];
  int            clr_t[$];
  int            done_t[$];
  logic [DB-1:0] done_v[$];
  int            err_t[$];
  int            busy_t[$];
  int            multi_hot = 0;

  always @(negedge clk) begin
    if (shift) begin
      shift_t.push_back(cyc);
      shift_i.push_back(int'(bit_idx));
    end
    if (sipo_clr)  clr_t.push_back(cyc);
    if (rx_done) begin
      done_t.push_back(cyc);
      done_v.push_back(dout);
    end
    if (frame_err) err_t.push_back(cyc);
    if (busy)      busy_t.push_back(cyc);
    if (int'(shift) + int'(sipo_clr) + int'(rx_done) + int'(frame_err) > 1) multi_hot++;
  end

  task automatic clear_log();
    shift_t.delete(); shift_i.delete(); clr_t.delete();
    done_t.delete(); done_v.delete(); err_t.delete(); busy_t.delete();
  endtask

  // Hold the line at a level for n clocks; always leaves us 1 time unit after an edge
  task automatic hold(input logic lvl, input int n);
    rxin = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one frame; e0 is the cycle number of the first edge that samples the start bit
  task automatic send_frame(input logic [DB-1:0] data, input logic stop, output int e0);
    e0 = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(data[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rxin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_bit, shift, sipo_clr, rx_done, frame_err, busy, bit_idx} !== 9'b1_0000_0_000) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b",
               {rx_bit, shift, sipo_clr, rx_done, frame_err, busy, bit_idx}, 9'b1_0000_0_000);
    end
    rst = 1'b0;
    hold(1'b1, 4);
  endtask

  task automatic test_basic_frame();
    int e0;
    clear_log();
    send_frame(5'b11101, 1'b1, e0);
    hold(1'b1, 20);
    checks++;
    if (shift_t.size() != DB) begin
      failures++;
      $display("FAIL basic_shift_count: got %0d expected %0d", shift_t.size(), DB);
    end else begin
      for (int k = 0; k < DB; k++) begin
        checks++;
        if (shift_t[k] - e0 != 25 + 16 * k || shift_i[k] != ((k + 1 < DB) ? k + 1 : DB - 1)) begin
          failures++;
          $display("FAIL basic_shift_%0d: at E%0d idx %0d expected E%0d idx %0d", k,
                   shift_t[k] - e0, shift_i[k], 25 + 16 * k, (k + 1 < DB) ? k + 1 : DB - 1);
        end
      end
    end
    checks++;
    if (clr_t.size() != 1 || (clr_t.size() == 1 && clr_t[0] - e0 != 9)) begin
      failures++;
      $display("FAIL basic_clr: count %0d first E%0d expected one at E9",
               clr_t.size(), (clr_t.size() > 0) ? clr_t[0] - e0 : -1);
    end
    checks++;
    if (done_t.size() != 1 || err_t.size() != 0) begin
      failures++;
      $display("FAIL basic_done_count: done %0d err %0d expected 1 and 0", done_t.size(), err_t.size());
    end else begin
      checks++;
      if (done_t[0] - e0 != 105 || done_v[0] !== 5'b11101) begin
        failures++;
        $display("FAIL basic_done: E%0d dout %b expected E105 dout 11101", done_t[0] - e0, done_v[0]);
      end
    end
    checks++;
    if (busy_t.size() != 103 || (busy_t.size() > 0 && busy_t[0] - e0 != 2)) begin
      failures++;
      $display("FAIL basic_busy: %0d cycles first E%0d expected 103 from E2",
               busy_t.size(), (busy_t.size() > 0) ? busy_t[0] - e0 : -1);
    end
  endtask

  task automatic test_glitch();
    int e0;
    clear_log();
    e0 = cyc + 1;
    hold(1'b0, 4);
    hold(1'b1, 30);
    checks++;
    if (clr_t.size() + shift_t.size() + done_t.size() + err_t.size() != 0) begin
      failures++;
      $display("FAIL glitch_strobes: clr %0d shift %0d done %0d err %0d expected none",
               clr_t.size(), shift_t.size(), done_t.size(), err_t.size());
    end
    checks++;
    if (busy_t.size() != 7 || (busy_t.size() == 7 && (busy_t[0] - e0 != 2 || busy_t[6] - e0 != 8))) begin
      failures++;
      $display("FAIL glitch_busy: %0d cycles first E%0d expected 7 cycles E2..E8",
               busy_t.size(), (busy_t.size() > 0) ? busy_t[0] - e0 : -1);
    end
  endtask

  task automatic test_break();
    int e0;
    logic [DB-1:0] d;
    clear_log();
    d = DB'($urandom);
    send_frame(d, 1'b0, e0);
    hold(1'b0, 40);
    checks++;
    if (err_t.size() != 1 || done_t.size() != 0 || (err_t.size() == 1 && err_t[0] - e0 != 105)) begin
      failures++;
      $display("FAIL break_err: err %0d done %0d first E%0d expected one err at E105",
               err_t.size(), done_t.size(), (err_t.size() > 0) ? err_t[0] - e0 : -1);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL break_busy: got %b expected 1", busy);
    end
    hold(1'b1, 10);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_release: busy %b expected 0", busy);
    end
    clear_log();
    d = DB'($urandom);
    send_frame(d, 1'b1, e0);
    hold(1'b1, 10);
    checks++;
    if (done_t.size() != 1 || (done_t.size() == 1 && (done_t[0] - e0 != 105 || done_v[0] !== d))) begin
      failures++;
      $display("FAIL break_next_frame: done %0d dout %b expected one at E105 dout %b",
               done_t.size(), (done_v.size() > 0) ? done_v[0] : 5'bx, d);
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1;
    clear_log();
    send_frame(5'h0A, 1'b1, e0);
    send_frame(5'h15, 1'b1, e1);
    hold(1'b1, 20);
    checks++;
    if (done_t.size() != 2 || shift_t.size() != 2 * DB || err_t.size() != 0) begin
      failures++;
      $display("FAIL b2b_counts: done %0d shift %0d err %0d expected 2 %0d 0",
               done_t.size(), shift_t.size(), err_t.size(), 2 * DB);
    end else begin
      checks++;
      if (done_t[0] - e0 != 105 || done_t[1] - done_t[0] != FRAME ||
          done_v[0] !== 5'h0A || done_v[1] !== 5'h15) begin
        failures++;
        $display("FAIL b2b_frames: E%0d gap %0d dout %h %h expected E105 gap %0d dout 0a 15",
                 done_t[0] - e0, done_t[1] - done_t[0], done_v[0], done_v[1], FRAME);
      end
    end
  endtask

  task automatic test_random_frames();
    int            e0;
    int            exp_t[$];
    logic [DB-1:0] exp_v[$];
    logic [DB-1:0] d;
    clear_log();
    for (int n = 0; n < 8; n++) begin
      d = DB'($urandom);
      send_frame(d, 1'b1, e0);
      exp_t.push_back(e0 + 105);
      exp_v.push_back(d);
      hold(1'b1, $urandom_range(0, 30));
    end
    hold(1'b1, 10);
    checks++;
    if (done_t.size() != exp_t.size() || shift_t.size() != DB * exp_t.size() || err_t.size() != 0) begin
      failures++;
      $display("FAIL rand_counts: done %0d shift %0d err %0d expected %0d %0d 0",
               done_t.size(), shift_t.size(), err_t.size(), exp_t.size(), DB * exp_t.size());
    end else begin
      for (int n = 0; n < exp_t.size(); n++) begin
        checks++;
        if (done_t[n] != exp_t[n] || done_v[n] !== exp_v[n]) begin
          failures++;
          $display("FAIL rand_frame_%0d: cycle %0d dout %h expected cycle %0d dout %h",
                   n, done_t[n], done_v[n], exp_t[n], exp_v[n]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [DB-1:0] d;
    clear_log();
    e0 = cyc + 1;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 3);
    rst = 1'b1;
    #1;
    checks++;
    if ({rx_bit, shift, sipo_clr, rx_done, frame_err, busy, bit_idx} !== 9'b1_0000_0_000) begin
      failures++;
      $display("FAIL midreset_state: got %b expected %b at E%0d",
               {rx_bit, shift, sipo_clr, rx_done, frame_err, busy, bit_idx}, 9'b1_0000_0_000, cyc - e0);
    end
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 80);
    checks++;
    if (done_t.size() != 0 || err_t.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abandon: done %0d err %0d busy %b expected 0 0 0",
               done_t.size(), err_t.size(), busy);
    end
    clear_log();
    d = DB'($urandom);
    send_frame(d, 1'b1, e0);
    hold(1'b1, 10);
    checks++;
    if (done_t.size() != 1 || (done_t.size() == 1 && (done_t[0] - e0 != 105 || done_v[0] !== d))) begin
      failures++;
      $display("FAIL midreset_next_frame: done %0d dout %b expected one at E105 dout %b",
               done_t.size(), (done_v.size() > 0) ? done_v[0] : 5'bx, d);
    end
  endtask

  task automatic test_idle_long();
    clear_log();
    hold(1'b1, 500);
    checks++;
    if (busy_t.size() + shift_t.size() + clr_t.size() + done_t.size() + err_t.size() != 0) begin
      failures++;
      $display("FAIL idle_quiet: busy %0d shift %0d clr %0d done %0d err %0d expected all 0",
               busy_t.size(), shift_t.size(), clr_t.size(), done_t.size(), err_t.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_break();
    test_back_to_back();
    test_random_frames();
    test_reset_mid();
    test_idle_long();
    checks++;
    if (multi_hot != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: %0d cycles with more than one strobe, expected 0", multi_hot);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
